// File: rtl/bus_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_4
// Purpose  : Four-way round-robin arbiter for the shared port mux. Drives a
//            one-hot grant and the mux select, holds a grant until the owner
//            drops its request or the hold limit expires, and always leaves
//            one grant-free cycle between owners.
// Revision : 1.0  initial release
// ============================================================================
module bus_arbiter_4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  output logic [3:0] grant_o,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic       preempt_o
);

  // Hold counter is at least one bit wide so MAX_HOLD = 0 still elaborates.
  localparam int              HCW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0]  C_MAX = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0]  C_ONE = HCW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]     state_q,   state_d;
  logic [3:0]     grant_q,   grant_d;
  logic [1:0]     sel_q,     sel_d;
  logic [1:0]     ptr_q,     ptr_d;
  logic [HCW-1:0] hold_q,    hold_d;
  logic           preempt_q, preempt_d;

  logic           win_valid;
  logic [1:0]     win_idx;

  // Pick the first requester at or after ptr; scanning from the farthest
  // offset down lets the nearest one overwrite and win.
  always_comb begin
    win_valid = |req_i;
    win_idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req_i[ptr_q + 2'(k)]) begin
        win_idx = ptr_q + 2'(k);
      end
    end
  end

  // Next-state logic. sel_q doubles as the owner index while BUSY.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        grant_d = 4'b0000;
        if (win_valid) begin
          state_d = S_BUSY;
          grant_d = 4'b0001 << win_idx;
          sel_d   = win_idx;
          hold_d  = C_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (!req_i[sel_q]) begin
          // Owner released: move priority past it and take a gap cycle.
          state_d = S_GAP;
          grant_d = 4'b0000;
          ptr_d   = sel_q + 2'd1;
        end else if ((MAX_HOLD != 0) && (hold_q == C_MAX)) begin
          // Hold limit reached: forced release, flagged for one cycle.
          state_d   = S_GAP;
          grant_d   = 4'b0000;
          ptr_d     = sel_q + 2'd1;
          preempt_d = 1'b1;
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + C_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 4'b0000;
      sel_q     <= 2'b00;
      ptr_q     <= 2'b00;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant_o   = grant_q;
  assign sel_o     = sel_q;
  assign busy_o    = |grant_q;
  assign preempt_o = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_4
// Purpose  : Self-checking bench for bus_arbiter_4. Two instances (hold limit
//            4 and hold limit disabled) share stimulus; each is compared
//            every cycle against a behavioural model of the arbitration rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] g4, g0;
  logic [1:0] s4, s0;
  logic       b4, b0, p4, p0;

  int checks = 0;
  int errors = 0;

  // Model state per instance: index 0 -> MAX_HOLD=4, index 1 -> MAX_HOLD=0.
  int m_hold [2] = '{4, 0};
  int m_owner[2];
  int m_cnt  [2];
  int m_ptr  [2];
  int m_pre  [2];
  int m_sel  [2];

  always #5 clk = ~clk;

  bus_arbiter_4 #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_i(req),
    .grant_o(g4), .sel_o(s4), .busy_o(b4), .preempt_o(p4)
  );

  bus_arbiter_4 #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req),
    .grant_o(g0), .sel_o(s0), .busy_o(b0), .preempt_o(p0)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the arbitration rules, owner = -1 meaning no grant.
  task automatic model_step(input logic [3:0] r, input logic rn);
    for (int d = 0; d < 2; d++) begin
      if (!rn) begin
        m_owner[d] = -1; m_cnt[d] = 0; m_ptr[d] = 0; m_pre[d] = 0; m_sel[d] = 0;
      end else if (m_owner[d] >= 0) begin
        if (!r[m_owner[d]]) begin
          m_pre[d] = 0; m_ptr[d] = (m_owner[d] + 1) % 4; m_owner[d] = -1;
        end else if (m_hold[d] != 0 && m_cnt[d] == m_hold[d]) begin
          m_pre[d] = 1; m_ptr[d] = (m_owner[d] + 1) % 4; m_owner[d] = -1;
        end else begin
          m_cnt[d]++;
        end
      end else begin
        m_pre[d] = 0;
        for (int k = 0; k < 4; k++) begin
          if (m_owner[d] < 0 && r[(m_ptr[d] + k) % 4]) begin
            m_owner[d] = (m_ptr[d] + k) % 4;
            m_sel[d]   = m_owner[d];
            m_cnt[d]   = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg [2];
    for (int d = 0; d < 2; d++) begin
      eg[d] = (m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]);
    end
    check("grant_h4",   8'(g4), 8'(eg[0]));
    check("sel_h4",     8'(s4), 8'(m_sel[0]));
    check("busy_h4",    8'(b4), 8'(m_owner[0] >= 0));
    check("preempt_h4", 8'(p4), 8'(m_pre[0]));
    check("grant_h0",   8'(g0), 8'(eg[1]));
    check("sel_h0",     8'(s0), 8'(m_sel[1]));
    check("busy_h0",    8'(b0), 8'(m_owner[1] >= 0));
    check("preempt_h0", 8'(p0), 8'(m_pre[1]));
  endtask

  // Drive at negedge, model the posedge, sample 1 time unit after it.
  task automatic tick(input logic [3:0] r, input logic rn);
    @(negedge clk);
    req   = r;
    rst_n = rn;
    @(posedge clk);
    model_step(r, rn);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] rr;
    logic       rn;
    req   = 4'b0000;
    rst_n = 1'b0;

    // Reset with every requester asserted, then release.
    repeat (3) tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b1);
    check("first_grant", 8'(g4), 8'h01);
    check("first_sel",   8'(s4), 8'h00);
    // All four requesting: rotating forced releases on the limited instance.
    repeat (25) tick(4'b1111, 1'b1);

    // Single requester 2 for five cycles.
    tick(4'b0000, 1'b0);
    repeat (2) tick(4'b0000, 1'b1);
    repeat (5) tick(4'b0100, 1'b1);
    check("single_sel_last", 8'(s4), 8'h02);
    repeat (3) tick(4'b0000, 1'b1);
    check("single_sel_after", 8'(s4), 8'h02);

    // Fairness: 1 owns, releases while 0 and 3 request -> 3 next, then 0.
    tick(4'b0000, 1'b0);
    tick(4'b0010, 1'b1);
    repeat (2) tick(4'b1011, 1'b1);
    tick(4'b1001, 1'b1);
    tick(4'b1001, 1'b1);
    check("fair_next_owner", 8'(g0), 8'h08);
    // Disabled limit: owner 3 keeps the grant for 100 cycles despite others.
    repeat (100) tick(4'b1111, 1'b1);
    check("nolimit_owner", 8'(g0), 8'h08);

    // Reset in the middle of a grant (owner 2, three cycles held).
    tick(4'b0000, 1'b0);
    repeat (3) tick(4'b0100, 1'b1);
    tick(4'b0100, 1'b0);
    check("midreset_grant", 8'(g4), 8'h00);
    check("midreset_sel",   8'(s4), 8'h00);
    tick(4'b0101, 1'b1);
    check("post_reset_winner", 8'(g4), 8'h01);

    // Randomised run: sticky requests with occasional toggles and resets.
    rr = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) rr[b] = ~rr[b];
      end
      rn = ($urandom_range(59) != 0);
      tick(rr, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
